// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider_pkg
// Purpose  : Shared types and constants for the sequential restoring divider
// Revision : 1.0 - initial release
// ============================================================================
package seq_restoring_divider_pkg;

  // Operand/result width used when the top is instantiated without overrides
  localparam int c_default_width = 8;

  // Controller states; explicit width keeps the encoding stable across tools
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Iteration counter width: counts WIDTH-1 down to 0
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_n
// Purpose  : N-bit ripple adder/subtractor. mode=1 adds, mode=0 subtracts
//            using the inverted operand plus a carry-in of 1.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         mode,
  output logic [N-1:0] sum,
  output logic         carry
);

  logic [N:0]   w_c;
  logic [N-1:0] w_b;

  // Subtract is a + ~b + 1: invert b and inject the +1 as carry-in
  assign w_b    = mode ? b : ~b;
  assign w_c[0] = ~mode;

  // One full-adder cell per bit, carry rippling LSB to MSB
  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign sum[i]   = a[i] ^ w_b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & w_b[i]) | (w_c[i] & (a[i] ^ w_b[i]));
    end
  endgenerate

  assign carry = w_c[N];

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider
// Purpose  : Multi-cycle unsigned divider, one quotient bit per clock using a
//            restoring shift-subtract loop behind a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;

  // Partial remainder. The extra top bit of the (WIDTH+1)-bit accumulator is
  // always zero between iterations (A < D), so only WIDTH bits are stored.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_t;
  logic             w_borrow;
  logic             w_carry_unused;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_q_next;

  // Shift next dividend bit into the partial remainder, then trial-subtract D
  assign w_s = {r_a, r_q[WIDTH-1]};

  add_sub_n #(
    .N     (WIDTH + 1)
  ) u_sub (
    .a     (w_s),
    .b     ({1'b0, r_d}),
    .mode  (1'b0),
    .sum   (w_t),
    .carry (w_carry_unused)
  );

  // Negative trial result (sum MSB set) means D did not fit: restore S
  assign w_borrow = w_t[WIDTH];
  assign w_a_next = w_borrow ? w_s[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};

  // Handshake flags decode straight from the state register
  assign ready = (r_state == S_IDLE);
  assign done  = (r_state == S_FIN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: zero divisor skips the iteration loop entirely
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (divisor != '0) ? S_CALC : S_FIN;
      S_CALC:  if (r_cnt == '0) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle iteration, and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_a         <= '0;
              r_q         <= dividend;
              r_d         <= divisor;
              r_cnt       <= c_cnt_load;
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_a <= w_a_next;
          r_q <= w_q_next;
          if (r_cnt == '0) begin
            quotient  <= w_q_next;
            remainder <= w_a_next;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_restoring_divider
// Purpose  : Directed and random checks of seq_restoring_divider (WIDTH=8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int vectors;
  int miscompares;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one division from a negedge; lat = cycles from start cycle to done
  // cycle, or -1 if done never arrives. Returns on the negedge done is seen.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    vectors++;
    if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b done=%b q=%0d r=%0d dbz=%b, want 1 0 0 0 0",
               ready, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ready_low: got %b want 0", ready);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d want 9", lat);
    end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_100/7: got q=%0d r=%0d dbz=%b want 14 2 0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_after_done: got rdy=%b done=%b want 1 0", ready, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_div(8'd255, 8'd1, lat);
    vectors++;
    if (lat !== 9 || quotient !== 8'd255 || remainder !== 8'd0) begin
      miscompares++;
      $display("FAIL b2b_255/1: got lat=%0d q=%0d r=%0d want 9 255 0", lat, quotient, remainder);
    end
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_return: got %b want 1", ready);
    end
    do_div(8'd0, 8'd13, lat);
    vectors++;
    if (lat !== 9 || quotient !== 8'd0 || remainder !== 8'd0) begin
      miscompares++;
      $display("FAIL b2b_0/13: got lat=%0d q=%0d r=%0d want 9 0 0", lat, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_edges();
    int lat;
    do_div(8'd5, 8'd9, lat);
    vectors++;
    if (lat !== 9 || quotient !== 8'd0 || remainder !== 8'd5) begin
      miscompares++;
      $display("FAIL edge_5/9: got lat=%0d q=%0d r=%0d want 9 0 5", lat, quotient, remainder);
    end
    @(negedge clk);
    do_div(8'd200, 8'd200, lat);
    vectors++;
    if (lat !== 9 || quotient !== 8'd1 || remainder !== 8'd0) begin
      miscompares++;
      $display("FAIL edge_200/200: got lat=%0d q=%0d r=%0d want 9 1 0", lat, quotient, remainder);
    end
    @(negedge clk);
    do_div(8'd250, 8'd255, lat);
    vectors++;
    if (lat !== 9 || quotient !== 8'd0 || remainder !== 8'd250) begin
      miscompares++;
      $display("FAIL edge_250/255: got lat=%0d q=%0d r=%0d want 9 0 250", lat, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat;
    do_div(8'd37, 8'd0, lat);
    vectors++;
    if (lat !== 1 || {quotient, remainder, div_by_zero} !== {8'hFF, 8'd37, 1'b1}) begin
      miscompares++;
      $display("FAIL dbz_37/0: got lat=%0d q=%0d r=%0d dbz=%b want 1 255 37 1",
               lat, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    vectors++;
    if (div_by_zero !== 1'b1 || quotient !== 8'hFF) begin
      miscompares++;
      $display("FAIL dbz_hold: got dbz=%b q=%0d want 1 255", div_by_zero, quotient);
    end
    do_div(8'd9, 8'd3, lat);
    vectors++;
    if (lat !== 9 || {quotient, remainder, div_by_zero} !== {8'd3, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL dbz_clear_9/3: got lat=%0d q=%0d r=%0d dbz=%b want 9 3 0 0",
               lat, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_busy();
    int lat;
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    // Throw conflicting requests at the busy divider, including a zero divisor
    for (int k = 0; k < 4; k++) begin
      dividend = 8'(50 + k); divisor = (k == 2) ? 8'd0 : 8'(3 + k); start = 1'b1;
      @(negedge clk); lat++;
      start = 1'b0;
      @(negedge clk); lat++;
    end
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    vectors++;
    if (lat !== 9 || {quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL busy_ignore: got lat=%0d q=%0d r=%0d dbz=%b want 9 14 2 0",
               lat, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    dividend = 8'd77; divisor = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    // Now in the fourth CALC cycle
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got rdy=%b done=%b q=%0d r=%0d dbz=%b want 1 0 0 0 0",
               ready, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    vectors++;
    if (seen_done !== 0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_abort: got done_seen=%0d rdy=%b want 0 1", seen_done, ready);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] a, b, eq, er;
    logic edbz;
    for (int n = 0; n < 1500; n++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'hFF; er = a; edbz = 1'b1;
      end else begin
        eq = a / b; er = a % b; edbz = 1'b0;
      end
      do_div(a, b, lat);
      vectors++;
      if (lat !== ((b == 8'd0) ? 1 : 9) || {quotient, remainder, div_by_zero} !== {eq, er, edbz}) begin
        miscompares++;
        $display("FAIL random_%0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                 a, b, lat, quotient, remainder, div_by_zero, eq, er, edbz);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_edges();
    test_div_zero();
    test_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
